// File: rtl/oscilloscope.sv
// Oscilloscope capture engine: on a synchronized trigger edge, streams 256
// X/Y samples as frame-buffer pixel writes, then waits out a holdoff period.
module oscilloscope (
  input  logic        clk_25,
  input  logic        rst_n,
  input  logic        clk_62_5,
  input  logic        trigger,
  input  logic [7:0]  in_x,
  input  logic [7:0]  in_y,
  output logic [7:0]  out_x,
  output logic [7:0]  out_y,
  output logic        write_en,
  output logic [11:0] RGB
);

  typedef enum logic [1:0] {
    ARMED   = 2'd0,
    CAPTURE = 2'd1,
    HOLDOFF = 2'd2
  } state_t;

  localparam logic [11:0] RGB_GREEN  = 12'h0F0;
  localparam logic [11:0] RGB_YELLOW = 12'hFF0;
  localparam logic [7:0]  AXIS_MID   = 8'd128;

  state_t      state;
  state_t      state_next;
  logic        sync1;
  logic        sync2;
  logic        sync2_d;
  logic [1:0]  primed;
  logic        seen_low;
  logic        trig_rise;
  logic [7:0]  sample_cnt;
  logic [9:0]  hold_cnt;

  // Reserved pin; tied off so it cannot influence any output.
  logic unused_clk_62_5;
  assign unused_clk_62_5 = clk_62_5;

  // Trigger synchronizer and edge history. The synchronizer clears to 0, so a
  // trigger held high through reset would look like a fresh edge; seen_low
  // blocks edges until the synchronized trigger has been observed low once
  // after the synchronizer has refilled (primed) following reset.
  always_ff @(posedge clk_25) begin
    // NOTE: sequential state always uses non-blocking assignments so every
    // flop samples the pre-edge values, matching the hardware.
    if (rst_n) begin
      sync1    <= 1'b0;
      sync2    <= 1'b0;
      sync2_d  <= 1'b0;
      primed   <= 2'b00;
      seen_low <= 1'b0;
    end else begin
      sync1   <= trigger;
      sync2   <= sync1;
      sync2_d <= sync2;
      primed  <= {primed[0], 1'b1};
      if (primed[1] && !sync2) begin
        seen_low <= 1'b1;
      end
    end
  end

  assign trig_rise = sync2 & ~sync2_d & seen_low;

  // State register.
  always_ff @(posedge clk_25) begin
    if (rst_n) begin
      state <= ARMED;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; edges outside ARMED are simply dropped, never queued.
  always_comb begin
    // NOTE: assigning a default first guarantees every path drives
    // state_next, so no latch is inferred.
    state_next = state;
    case (state)
      ARMED:   if (trig_rise)             state_next = CAPTURE;
      CAPTURE: if (sample_cnt == 8'd255)  state_next = HOLDOFF;
      HOLDOFF: if (hold_cnt == 10'd1023)  state_next = ARMED;
      default:                            state_next = ARMED;
    endcase
  end

  // Sample and holdoff counters; each wraps to 0 exactly as its state ends.
  always_ff @(posedge clk_25) begin
    if (rst_n) begin
      sample_cnt <= 8'd0;
      hold_cnt   <= 10'd0;
    end else begin
      case (state)
        CAPTURE: sample_cnt <= sample_cnt + 8'd1;
        HOLDOFF: hold_cnt   <= hold_cnt + 10'd1;
        default: ;
      endcase
    end
  end

  // Pixel output register: coordinates (Y flipped so row 0 is the top),
  // strobe and colour, all one cycle behind the sampled inputs.
  always_ff @(posedge clk_25) begin
    if (rst_n) begin
      out_x    <= 8'd0;
      out_y    <= 8'd0;
      write_en <= 1'b0;
      RGB      <= 12'h000;
    end else begin
      write_en <= (state == CAPTURE);
      if (state == CAPTURE) begin
        out_x <= in_x;
        out_y <= 8'd255 - in_y;
        RGB   <= (in_x == AXIS_MID || in_y == AXIS_MID) ? RGB_YELLOW : RGB_GREEN;
      end else begin
        RGB   <= 12'h000;
      end
    end
  end

endmodule

// File: tb/tb_oscilloscope.sv
// Directed testbench for the oscilloscope capture engine.
module tb_oscilloscope;

  logic        clk_25;
  logic        rst_n;
  logic        clk_62_5;
  logic        trigger;
  logic [7:0]  in_x;
  logic [7:0]  in_y;
  logic [7:0]  out_x;
  logic [7:0]  out_y;
  logic        write_en;
  logic [11:0] RGB;

  int vectors;
  int miscompares;

  oscilloscope dut (
    .clk_25   (clk_25),
    .rst_n    (rst_n),
    .clk_62_5 (clk_62_5),
    .trigger  (trigger),
    .in_x     (in_x),
    .in_y     (in_y),
    .out_x    (out_x),
    .out_y    (out_y),
    .write_en (write_en),
    .RGB      (RGB)
  );

  initial clk_25 = 1'b0;
  always #20 clk_25 = ~clk_25;

  // Reserved pin toggled at an unrelated rate for the whole run.
  initial clk_62_5 = 1'b0;
  always #7 clk_62_5 = ~clk_62_5;

  // Watchdog so the run always ends on its own.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Inputs change on the falling edge; outputs are observed on the next
  // falling edge, i.e. after the rising edge that sampled these inputs.
  task automatic step(input logic t, input logic [7:0] x, input logic [7:0] y);
    trigger = t;
    in_x    = x;
    in_y    = y;
    @(posedge clk_25);
    @(negedge clk_25);
  endtask

  function automatic logic [11:0] exp_rgb(input logic [7:0] x, input logic [7:0] y);
    return (x == 8'd128 || y == 8'd128) ? 12'hFF0 : 12'h0F0;
  endfunction

  task automatic check_write(input string tag, input logic [7:0] x, input logic [7:0] y);
    check({tag, "_x"},   32'(out_x), 32'(x));
    check({tag, "_y"},   32'(out_y), 32'(8'd255 - y));
    check({tag, "_rgb"}, 32'(RGB),   32'(exp_rgb(x, y)));
  endtask

  task automatic check_idle_zero(input string tag);
    check({tag, "_we"},  32'(write_en), 32'd0);
    check({tag, "_rgb"}, 32'(RGB),      32'd0);
    check({tag, "_x"},   32'(out_x),    32'd0);
    check({tag, "_y"},   32'(out_y),    32'd0);
  endtask

  initial begin
    int first_hi;
    int hi;
    int yellow;
    int fall_at;
    int second_hi;
    logic [7:0] lx;
    logic [7:0] ly;
    logic [7:0] v;

    vectors     = 0;
    miscompares = 0;
    rst_n   = 1'b1;
    trigger = 1'b0;
    in_x    = 8'd0;
    in_y    = 8'd0;

    // Reset, then trigger low: nothing written, all outputs zero.
    step(1'b0, 8'd9, 8'd9);
    step(1'b0, 8'd9, 8'd9);
    check_idle_zero("reset");
    rst_n = 1'b0;
    for (int c = 0; c < 10; c++) begin
      v = 8'(c * 7);
      step(1'b0, v, 8'd128);
      check_idle_zero("idle");
    end

    // Single rising edge, ramp on both channels, trigger held high after.
    first_hi = -1;
    hi       = 0;
    yellow   = 0;
    lx       = 8'd0;
    ly       = 8'd0;
    for (int c = 0; c < 300; c++) begin
      v = c[7:0];
      step(1'b1, v, v);
      if (write_en) begin
        if (first_hi < 0) first_hi = c;
        hi++;
        check_write("ramp", v, v);
        if (RGB == 12'hFF0) yellow++;
        lx = v;
        ly = 8'd255 - v;
      end else if (first_hi >= 0) begin
        check("ramp_hold_x",   32'(out_x), 32'(lx));
        check("ramp_hold_y",   32'(out_y), 32'(ly));
        check("ramp_hold_rgb", 32'(RGB),   32'd0);
      end
    end
    check("ramp_latency_ok", 32'((first_hi >= 3) && (first_hi <= 4)), 32'd1);
    check("ramp_burst_len",  32'(hi),     32'd256);
    check("ramp_yellow_cnt", 32'(yellow), 32'd1);

    // Let the holdoff expire with trigger low.
    for (int c = 0; c < 1100; c++) step(1'b0, 8'd0, 8'd0);

    // Trigger toggling every 62 cycles: rises at 0, 124, 248, ...
    // Burst 1 follows the rise at 0; holdoff ends 256+1024 cycles after it
    // starts, so the rise at 1240 is dropped and the next burst follows 1364.
    first_hi  = -1;
    fall_at   = -1;
    second_hi = -1;
    hi        = 0;
    for (int c = 0; c < 1420; c++) begin
      v = c[7:0];
      step(((c / 62) % 2) == 0, v, v + 8'd64);
      if (write_en) begin
        check_write("tog", v, v + 8'd64);
        if (first_hi < 0) first_hi = c;
        else if (fall_at >= 0 && second_hi < 0) second_hi = c;
        if (fall_at < 0) hi++;
      end else if (first_hi >= 0 && fall_at < 0) begin
        fall_at = c;
      end
    end
    check("tog_burst_len", 32'(hi),                   32'd256);
    check("tog_fall",      32'(fall_at - first_hi),   32'd256);
    check("tog_rearm_gap", 32'(second_hi - first_hi), 32'd1364);

    // Reset clears everything, then a fresh capture is aborted at sample 100.
    rst_n = 1'b1;
    step(1'b0, 8'd0, 8'd0);
    check_idle_zero("rst_mid_burst");
    rst_n = 1'b0;
    for (int c = 0; c < 5; c++) step(1'b0, 8'd0, 8'd0);
    hi = 0;
    for (int c = 0; c < 200 && hi < 100; c++) begin
      v = c[7:0];
      step(1'b1, v, 8'd200);
      if (write_en) hi++;
    end
    check("abort_samples", 32'(hi), 32'd100);
    rst_n = 1'b1;
    step(1'b1, 8'h55, 8'h66);
    check_idle_zero("abort");
    rst_n = 1'b0;

    // Trigger held high through reset release: no burst.
    hi = 0;
    for (int c = 0; c < 300; c++) begin
      step(1'b1, 8'h11, 8'h22);
      if (write_en) hi++;
    end
    check("held_high_no_burst", 32'(hi), 32'd0);

    // Low then high again: a normal burst follows.
    for (int c = 0; c < 5; c++) step(1'b0, 8'd0, 8'd0);
    first_hi = -1;
    hi       = 0;
    for (int c = 0; c < 300; c++) begin
      v = c[7:0];
      step(1'b1, v, 8'd128 - v);
      if (write_en) begin
        if (first_hi < 0) first_hi = c;
        hi++;
        check_write("post_rst", v, 8'd128 - v);
      end
    end
    check("post_rst_latency_ok", 32'((first_hi >= 3) && (first_hi <= 4)), 32'd1);
    check("post_rst_burst_len",  32'(hi), 32'd256);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
